// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the unified RAM port: instruction-fetch words vs LSB loads/stores.
// Define ARB_RR_EN for round-robin grant on contention; fixed LSB priority otherwise.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        br_reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;

  logic [31:0] addr_q, addr_nxt;
  logic [2:0]  nbytes_q, nbytes_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] rd_buf, rd_buf_nxt;
  logic        rr_ptr, rr_ptr_nxt;

  logic [31:0] mem_a_nxt;
  logic [7:0]  mem_dout_nxt;
  logic        mem_wr_nxt;
  logic        if_done_nxt, ls_done_nxt;
  logic [31:0] if_data_nxt, ls_rdata_nxt;

  logic        if_ok, ls_ok, pick_if, pick_ls;
  logic [2:0]  ls_n;
  logic [31:0] cur_addr;
  logic        io_stall_cur, io_stall_new;
  logic        rd_last, wr_last;
  logic [1:0]  cap_idx;

  // A flush blocks only speculative reads; stores are already committed.
  always_comb begin
    if_ok = if_req && !br_reset;
    ls_ok = ls_req && (ls_wr || !br_reset);
`ifdef ARB_RR_EN
    pick_if = if_ok && (!ls_ok || rr_ptr);
`else
    pick_if = if_ok && !ls_ok;
`endif
    pick_ls = ls_ok && !pick_if;
  end

  always_comb begin
    case (ls_size)
      2'd0:    ls_n = 3'd1;
      2'd1:    ls_n = 3'd2;
      default: ls_n = 3'd4;
    endcase
  end

  // Reads capture byte cnt-2 because RAM data trails the driven address by two edges.
  always_comb begin
    cur_addr     = addr_q + {29'd0, cnt};
    io_stall_cur = (cur_addr[17:16] == 2'b11) && io_buffer_full;
    io_stall_new = (ls_addr[17:16] == 2'b11) && io_buffer_full;
    rd_last      = (cnt == nbytes_q + 3'd1);
    wr_last      = (cnt == nbytes_q);
    cap_idx      = cnt[1:0] - 2'd2;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_ls) begin
          state_nxt = ls_wr ? LS_WR : LS_RD;
          cnt_nxt   = (ls_wr && io_stall_new) ? 3'd0 : 3'd1;
        end else if (pick_if) begin
          state_nxt = IF_RD;
          cnt_nxt   = 3'd1;
        end
      end
      IF_RD, LS_RD: begin
        if (br_reset || rd_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      LS_WR: begin
        if (wr_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!io_stall_cur) begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    mem_a_nxt    = mem_a;
    mem_dout_nxt = mem_dout;
    mem_wr_nxt   = mem_wr;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
    addr_nxt     = addr_q;
    nbytes_nxt   = nbytes_q;
    wdata_nxt    = wdata_q;
    rd_buf_nxt   = rd_buf;
    rr_ptr_nxt   = rr_ptr;
    case (state)
      IDLE: begin
        mem_wr_nxt = 1'b0;
        if (pick_ls) begin
          addr_nxt   = ls_addr;
          nbytes_nxt = ls_n;
          wdata_nxt  = ls_wdata;
          rd_buf_nxt = '0;
          mem_a_nxt  = ls_addr;
          rr_ptr_nxt = 1'b1;
          if (ls_wr) begin
            mem_dout_nxt = ls_wdata[7:0];
            mem_wr_nxt   = !io_stall_new;
          end
        end else if (pick_if) begin
          addr_nxt   = if_addr;
          nbytes_nxt = 3'd4;
          rd_buf_nxt = '0;
          mem_a_nxt  = if_addr;
          rr_ptr_nxt = 1'b0;
        end
      end
      IF_RD, LS_RD: begin
        if (br_reset) begin
          mem_a_nxt  = '0;
          mem_wr_nxt = 1'b0;
        end else begin
          if (cnt >= 3'd2)
            rd_buf_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
          if (rd_last) begin
            mem_a_nxt  = '0;
            mem_wr_nxt = 1'b0;
            if (state == IF_RD) begin
              if_done_nxt = 1'b1;
              if_data_nxt = rd_buf_nxt;
            end else begin
              ls_done_nxt  = 1'b1;
              ls_rdata_nxt = rd_buf_nxt;
            end
          end else if (cnt < nbytes_q) begin
            mem_a_nxt = cur_addr;
          end
        end
      end
      LS_WR: begin
        if (wr_last) begin
          ls_done_nxt = 1'b1;
          mem_a_nxt   = '0;
          mem_wr_nxt  = 1'b0;
        end else begin
          mem_a_nxt    = cur_addr;
          mem_dout_nxt = wdata_q[{cnt[1:0], 3'b000} +: 8];
          mem_wr_nxt   = !io_stall_cur;
        end
      end
      default: begin
        mem_a_nxt  = '0;
        mem_wr_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      if_data  <= '0;
      ls_done  <= 1'b0;
      ls_rdata <= '0;
      addr_q   <= '0;
      nbytes_q <= '0;
      wdata_q  <= '0;
      rd_buf   <= '0;
      rr_ptr   <= 1'b0;
    end else if (rdy_in) begin
      mem_a    <= mem_a_nxt;
      mem_dout <= mem_dout_nxt;
      mem_wr   <= mem_wr_nxt;
      if_done  <= if_done_nxt;
      if_data  <= if_data_nxt;
      ls_done  <= ls_done_nxt;
      ls_rdata <= ls_rdata_nxt;
      addr_q   <= addr_nxt;
      nbytes_q <= nbytes_nxt;
      wdata_q  <= wdata_nxt;
      rd_buf   <= rd_buf_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte RAM model, reference memory, randomized traffic.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, br_reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req, ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .br_reset(br_reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } sb_t;

  sb_t         if_q[$];
  sb_t         ls_q[$];
  logic [39:0] wlog[$];
  logic [7:0]  mdl [262144];
  logic [7:0]  ram [262144];

  int checks = 0, errors = 0, cyc = 0;
  int if_seen = 0, ls_seen = 0, last_if_cyc = 0, last_ls_cyc = 0;
  bit init_done = 1'b0;
  bit if_done_prev = 1'b0, ls_done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] ak;
    r = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      r[8*k +: 8] = mdl[ak[17:0]];
    end
    return r;
  endfunction

  // RAM: samples address/write at an edge, presents the read byte after it
  initial begin
    mem_din = '0;
    wait (init_done);
    for (int i = 0; i < 262144; i++) ram[i] = mdl[i];
    forever begin
      @(posedge clk_in);
      if (mem_wr) ram[mem_a[17:0]] = mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    sb_t it;
    if (rst_in) begin
      if (mem_wr) wlog.push_back({mem_a, mem_dout});
      if (if_done && !if_done_prev) begin
        if_seen++;
        last_if_cyc = cyc;
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_done_spurious: got if_done=1 at cycle %0d, expected none", cyc);
        end else begin
          it = if_q.pop_front();
          if (it.chk_data) chk("if_data", if_data, it.data);
          if (it.cyc != 0) chk("if_latency", cyc, it.cyc);
        end
      end
      if (ls_done && !ls_done_prev) begin
        ls_seen++;
        last_ls_cyc = cyc;
        if (ls_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ls_done_spurious: got ls_done=1 at cycle %0d, expected none", cyc);
        end else begin
          it = ls_q.pop_front();
          if (it.chk_data) chk("ls_rdata", ls_rdata, it.data);
          if (it.cyc != 0) chk("ls_latency", cyc, it.cyc);
        end
      end
    end
    if_done_prev = if_done;
    ls_done_prev = ls_done;
  end

  task automatic do_if(input logic [31:0] a, input int lat);
    sb_t it;
    int n, t;
    @(negedge clk_in); #1;
    it.data = mdl_rd(a, 4);
    it.chk_data = 1'b1;
    it.cyc = (lat < 0) ? 0 : cyc + 1 + lat;
    if_q.push_back(it);
    if_addr = a; if_req = 1'b1;
    n = if_seen; t = 0;
    while (if_seen == n && t < 100) begin @(negedge clk_in); #1; t++; end
    if_req = 1'b0;
    if (if_seen == n) begin
      checks++; errors++;
      $display("FAIL if_timeout: got no if_done for 0x%08h in %0d cycles, expected one", a, t);
      void'(if_q.pop_back());
    end
  endtask

  task automatic do_ls(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int lat);
    sb_t it;
    int n, t, nb;
    logic [31:0] ak;
    @(negedge clk_in); #1;
    nb = nbytes(sz);
    if (wr) begin
      for (int k = 0; k < nb; k++) begin
        ak = a + 32'(k);
        mdl[ak[17:0]] = wd[8*k +: 8];
      end
      it.data = '0; it.chk_data = 1'b0;
    end else begin
      it.data = mdl_rd(a, nb); it.chk_data = 1'b1;
    end
    it.cyc = (lat < 0) ? 0 : cyc + 1 + lat;
    ls_q.push_back(it);
    ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    n = ls_seen; t = 0;
    while (ls_seen == n && t < 100) begin @(negedge clk_in); #1; t++; end
    ls_req = 1'b0;
    if (ls_seen == n) begin
      checks++; errors++;
      $display("FAIL ls_timeout: got no ls_done for 0x%08h in %0d cycles, expected one", a, t);
      void'(ls_q.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, n0;
    logic [31:0] wd;
    rst_in = 1'b0; rdy_in = 1'b1; br_reset = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    for (int i = 0; i < 262144; i++) mdl[i] = 8'($urandom);
    mdl[32'h1000] = 8'h13; mdl[32'h1001] = 8'h05; mdl[32'h1002] = 8'h00; mdl[32'h1003] = 8'h00;
    init_done = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst_in = 1'b1;

    // contention straight out of reset: LSB first
    fork
      do_ls(1'b0, 2'd2, 32'h40, 32'h0, -1);
      do_if(32'h80, -1);
    join
    chk("contend_ls_first", last_if_cyc - last_ls_cyc, 6);

    do_ls(1'b0, 2'd2, 32'h44, 32'h0, 5);
    fork
      do_ls(1'b0, 2'd2, 32'h48, 32'h0, -1);
      do_if(32'h84, -1);
    join
`ifdef ARB_RR_EN
    chk("rr_alternate", last_ls_cyc - last_if_cyc, 6);
`else
    chk("fixed_ls_priority", last_if_cyc - last_ls_cyc, 6);
`endif

    base = wlog.size();
    do_if(32'h1000, 5);
    chk("fetch_word", if_data, 32'h00000513);
    chk("fetch_no_write", wlog.size() - base, 0);

    base = wlog.size();
    do_ls(1'b1, 2'd1, 32'h20, 32'hABCD1234, 2);
    chk("half_nwrites", wlog.size() - base, 2);
    if (wlog.size() >= base + 2) begin
      chk("half_w0", wlog[base], {32'h20, 8'h34});
      chk("half_w1", wlog[base+1], {32'h21, 8'h12});
    end
    do_ls(1'b0, 2'd0, 32'h21, 32'h0, 2);
    chk("byte_load_zext", ls_rdata, 32'h00000012);

    // flush at E2 of a fetch
    n0 = if_seen;
    @(negedge clk_in); #1;
    if_addr = 32'h200; if_req = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in); #1;
    br_reset = 1'b1; if_req = 1'b0;
    @(negedge clk_in);
    chk("br_fetch_mem_a", mem_a, 0);
    chk("br_fetch_mem_wr", mem_wr, 0);
    #1 br_reset = 1'b0;
    repeat (8) @(negedge clk_in);
    chk("br_fetch_no_done", if_seen - n0, 0);
    do_if(32'h204, 5);

    // flush during a committed store
    wd = $urandom;
    base = wlog.size();
    fork
      do_ls(1'b1, 2'd2, 32'h300, wd, 4);
      begin
        @(negedge clk_in); #1;
        @(negedge clk_in); #1 br_reset = 1'b1;
        @(negedge clk_in); #1;
        @(negedge clk_in); #1 br_reset = 1'b0;
      end
    join
    chk("br_store_nwrites", wlog.size() - base, 4);
    do_ls(1'b0, 2'd2, 32'h300, 32'h0, 5);

    // IO stall for three edges
    base = wlog.size();
    fork
      do_ls(1'b1, 2'd0, 32'h30000, 32'h5A, 4);
      begin
        @(negedge clk_in); #1 io_buffer_full = 1'b1;
        repeat (3) @(negedge clk_in);
        #1 io_buffer_full = 1'b0;
      end
    join
    chk("io_nwrites", wlog.size() - base, 1);
    if (wlog.size() >= base + 1) chk("io_write", wlog[base], {32'h30000, 8'h5A});

    // two frozen edges during a fetch
    fork
      do_if(32'h1000, 7);
      begin
        @(negedge clk_in); #1;
        @(negedge clk_in); #1 rdy_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in); #1 rdy_in = 1'b1;
      end
    join

    // asynchronous reset mid word-read
    @(negedge clk_in); #1;
    if_addr = 32'h1000; if_req = 1'b1;
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_mem_a", mem_a, 0);
    chk("arst_mem_wr", mem_wr, 0);
    chk("arst_mem_dout", mem_dout, 0);
    chk("arst_if_done", if_done, 0);
    chk("arst_if_data", if_data, 0);
    chk("arst_ls_done", ls_done, 0);
    chk("arst_ls_rdata", ls_rdata, 0);
    if_req = 1'b0;
    @(negedge clk_in); #1 rst_in = 1'b1;
    do_if(32'h1000, 5);

    for (int i = 0; i < 80; i++) begin
      int op;
      logic [31:0] a;
      logic [1:0] sz;
      op = $urandom_range(0, 2);
      a = $urandom_range(0, 32'h2FFFF);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
      case (op)
        0:       do_if(a, 5);
        1:       do_ls(1'b0, sz, a, 32'h0, nbytes(sz) + 1);
        default: do_ls(1'b1, sz, a, $urandom, nbytes(sz));
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_in);
    end

    repeat (4) @(negedge clk_in);
    chk("if_queue_drained", if_q.size(), 0);
    chk("ls_queue_drained", ls_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
